// File: rtl/clk_div_ratio_ctrl.sv
// Arbitrates divide-ratio change requests for one shared clock divider and
// retimes each change into the divider's low phase with a reset pulse and settle window.
module clk_div_ratio_ctrl #(
    parameter int NREQ       = 2,
    parameter int DIV_W      = 4,
    parameter int RST_CYC    = 2,
    parameter int SETTLE_CYC = 4,
    parameter int TMO_CYC    = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*DIV_W-1:0]   req_div_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [NREQ-1:0]         grant_o,
    output logic                    busy_o,
    output logic                    locked_o,
    input  logic                    out_clk_i,
    output logic [DIV_W-1:0]        div_in_o,
    output logic                    div_rst_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO_CYC + RST_CYC + SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ARB, S_WAIT_EDGE, S_APPLY, S_SETTLE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     own_q, own_d;
    logic              owned_q, owned_d;
    logic              first_q, first_d;
    logic [DIV_W-1:0]  ratio_q, ratio_d;
    logic [DIV_W-1:0]  div_in_q, div_in_d;
    logic [NREQ-1:0]   mask_q, mask_d;
    logic              oc_q;

    int                base;
    logic [PW-1:0]     idx;
    logic              win_vld;
    logic [PW-1:0]     win_idx;
    logic [DIV_W-1:0]  win_raw;
    logic [DIV_W-1:0]  win_ratio;
    logic [NREQ-1:0]   own_oh;
    logic [NREQ-1:0]   win_oh;

    // Round-robin search; base of NREQ-1 makes the very first search start at 0.
    always_comb begin
        base    = first_q ? NREQ - 1 : int'(ptr_q);
        idx     = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((base + k) % NREQ);
            if (req_i[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
        win_raw   = req_div_i[int'(win_idx)*DIV_W +: DIV_W];
        win_ratio = (win_raw == '0) ? DIV_W'(1) : win_raw;
        own_oh    = NREQ'(1) << own_q;
        win_oh    = NREQ'(1) << win_idx;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        owned_d  = owned_q;
        first_d  = first_q;
        ratio_d  = ratio_q;
        div_in_d = div_in_q;
        mask_d   = '0;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                if (|(req_i & ~mask_q)) state_d = S_ARB;
            end
            S_ARB: begin
                state_d = S_IDLE;
                if (win_vld) begin
                    own_d   = win_idx;
                    owned_d = 1'b1;
                    ratio_d = win_ratio;
                    cnt_d   = '0;
                    state_d = (win_ratio == div_in_q) ? S_DONE : S_WAIT_EDGE;
                end
            end
            S_WAIT_EDGE: begin
                cnt_d = cnt_q + 1'b1;
                // The timeout keeps a stopped divider from wedging the arbiter.
                if ((oc_q && !out_clk_i) || cnt_q == CW'(TMO_CYC - 1)) begin
                    state_d  = S_APPLY;
                    cnt_d    = '0;
                    div_in_d = ratio_q;
                end
            end
            S_APPLY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    state_d = owned_q ? S_DONE : S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                ptr_d   = own_q;
                owned_d = 1'b0;
                first_d = 1'b0;
                mask_d  = own_oh;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            ptr_q    <= '0;
            own_q    <= '0;
            owned_q  <= 1'b0;
            first_q  <= 1'b1;
            ratio_q  <= '0;
            div_in_q <= '1;
            mask_q   <= '0;
            oc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            own_q    <= own_d;
            owned_q  <= owned_d;
            first_q  <= first_d;
            ratio_q  <= ratio_d;
            div_in_q <= div_in_d;
            mask_q   <= mask_d;
            oc_q     <= out_clk_i;
        end
    end

    always_comb begin
        ack_o     = '0;
        grant_o   = '0;
        busy_o    = 1'b1;
        locked_o  = 1'b1;
        div_rst_o = 1'b0;
        case (state_q)
            S_INIT: begin
                div_rst_o = 1'b1;
                locked_o  = 1'b0;
            end
            S_IDLE:      busy_o  = 1'b0;
            S_ARB:       grant_o = win_vld ? win_oh : '0;
            S_WAIT_EDGE: grant_o = own_oh;
            S_APPLY: begin
                grant_o   = own_oh;
                div_rst_o = 1'b1;
                locked_o  = 1'b0;
            end
            S_SETTLE: begin
                grant_o  = owned_q ? own_oh : '0;
                locked_o = 1'b0;
            end
            S_DONE: begin
                grant_o = own_oh;
                ack_o   = own_oh;
            end
            default: ;
        endcase
    end

    assign div_in_o = div_in_q;
endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Bench for clk_div_ratio_ctrl: table of single requests plus hand sequences for
// reset, edge wait, timeout, ties and mid-settle reset; ACKs are matched against a queue.
module tb_clk_div_ratio_ctrl;
    localparam int RST_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [7:0] req_div = '0;
    logic [1:0] ack, grant;
    logic       busy, locked, div_rst;
    logic       out_clk = 1'b0;
    logic [3:0] div_in;

    clk_div_ratio_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_div_i(req_div),
        .ack_o(ack), .grant_o(grant), .busy_o(busy), .locked_o(locked),
        .out_clk_i(out_clk), .div_in_o(div_in), .div_rst_o(div_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ack;
        logic [3:0] div;
        bit         noop;
    } exp_t;

    typedef struct {
        int         who;
        logic [3:0] ratio;
        bit         late;
        logic [3:0] exp_div;
        bit         noop;
    } vec_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   rst_run = 0, last_run = 0, pulses = 0;
    bit   late_drop[2] = '{0, 0};
    int   drop_cnt[2] = '{0, 0};
    bit   oc_auto = 1'b1;
    bit   oc_man = 1'b0;
    int   oc_div = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Divider output model: free-running slow toggle, or a level held by the test.
    initial forever begin
        @(negedge clk);
        if (oc_auto) begin
            oc_div++;
            if (oc_div == 3) begin
                oc_div  = 0;
                out_clk = ~out_clk;
            end
        end else begin
            out_clk = oc_man;
        end
    end

    // Monitor + requester model: pop expectation on each ACK, then drop REQ.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (div_rst) rst_run++;
        else if (rst_run != 0) begin
            last_run = rst_run;
            rst_run  = 0;
            pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            if (drop_cnt[i] > 0) begin
                drop_cnt[i]--;
                if (drop_cnt[i] == 0) req[i] = 1'b0;
            end
        end
        if (ack != 2'b00) begin
            if (sbq.size() == 0) chk("ack_unexpected", int'(ack), 0);
            else begin
                e = sbq.pop_front();
                chk("ack_id", int'(ack), int'(e.ack));
                chk("ack_div_in", int'(div_in), int'(e.div));
                chk("ack_grant", int'(grant), int'(e.ack));
                chk("ack_locked", int'(locked), 1);
                chk("ack_rst_pulses", pulses, e.noop ? 0 : 1);
                if (!e.noop) chk("div_rst_len", last_run, RST_CYC);
            end
            pulses = 0;
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    if (late_drop[i]) drop_cnt[i] = 2;
                    else req[i] = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int who, input logic [3:0] r, input bit late,
                         input logic [3:0] expd, input bit noop);
        exp_t e;
        @(negedge clk);
        req_div[who*4 +: 4] = r;
        late_drop[who] = late;
        e.ack  = 2'(1 << who);
        e.div  = expd;
        e.noop = noop;
        sbq.push_back(e);
        req[who] = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sbq.size(), 0);
        n = 0;
        while ((busy || req != 2'b00) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("return_idle", int'(n < 200), 1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        sbq.delete();
        late_drop = '{0, 0};
        drop_cnt  = '{0, 0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        rst_run = 0;
        pulses  = 0;
    endtask

    vec_t tbl[6];

    initial begin
        int n;
        tbl[0] = '{who: 1, ratio: 4'd3,  late: 0, exp_div: 4'd3,  noop: 1};
        tbl[1] = '{who: 1, ratio: 4'd0,  late: 0, exp_div: 4'd1,  noop: 0};
        tbl[2] = '{who: 0, ratio: 4'd1,  late: 0, exp_div: 4'd1,  noop: 1};
        tbl[3] = '{who: 0, ratio: 4'd12, late: 1, exp_div: 4'd12, noop: 0};
        tbl[4] = '{who: 1, ratio: 4'd15, late: 0, exp_div: 4'd15, noop: 0};
        tbl[5] = '{who: 0, ratio: 4'd7,  late: 0, exp_div: 4'd7,  noop: 0};

        // Reset values, then release timing.
        repeat (5) @(posedge clk);
        #1;
        chk("rst_div_in", int'(div_in), 15);
        chk("rst_div_rst", int'(div_rst), 1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_grant", int'(grant), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("init_div_rst_c1", int'(div_rst), 1);
        @(posedge clk); #1;
        chk("init_div_rst_c2", int'(div_rst), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("init_locked_c5", int'(locked), 0);
        @(posedge clk); #1;
        chk("init_locked_c6", int'(locked), 1);
        chk("init_busy_c6", int'(busy), 0);
        rst_run = 0;
        pulses  = 0;

        // Change held off while OUT_CLK stays high, applied on its fall.
        oc_auto = 1'b0;
        oc_man  = 1'b1;
        repeat (3) @(negedge clk);
        issue(0, 4'd3, 0, 4'd3, 0);
        repeat (12) @(negedge clk);
        chk("hold_div_in", int'(div_in), 15);
        chk("hold_div_rst", int'(div_rst), 0);
        chk("hold_grant", int'(grant), 1);
        chk("hold_busy", int'(busy), 1);
        oc_man = 1'b0;
        drain();
        chk("edge_div_in", int'(div_in), 3);
        oc_auto = 1'b1;

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].who, tbl[i].ratio, tbl[i].late, tbl[i].exp_div, tbl[i].noop);
            drain();
            chk("tbl_div_in", int'(div_in), int'(tbl[i].exp_div));
        end

        // No-op request: ACK two edges after IDLE samples REQ.
        issue(1, 4'd7, 0, 4'd7, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("noop_ack_latency", int'(ack), 2);
        chk("noop_locked", int'(locked), 1);
        drain();

        // Stuck divider: timeout forces the apply.
        oc_auto = 1'b0;
        oc_man  = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 4'd9, 0, 4'd9, 0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!div_rst && n < 200);
        chk("timeout_latency", n, 66);
        drain();
        chk("timeout_div_in", int'(div_in), 9);
        oc_auto = 1'b1;

        // Tie after reset goes to req0; a re-raised req0 then loses to pending req1.
        reset_dut();
        @(negedge clk);
        req_div = {4'd7, 4'd5};
        sbq.push_back('{ack: 2'b01, div: 4'd5, noop: 1'b0});
        sbq.push_back('{ack: 2'b10, div: 4'd7, noop: 1'b0});
        req = 2'b11;
        n = 0;
        while (!ack[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tie_first_ack0", int'(ack[0]), 1);
        @(negedge clk);
        sbq.push_back('{ack: 2'b01, div: 4'd5, noop: 1'b0});
        req[0] = 1'b1;
        drain();
        chk("tie_div_in", int'(div_in), 5);

        // Reset landing in SETTLE drops the request silently.
        issue(0, 4'd6, 0, 4'd6, 0);
        n = 0;
        while (!div_rst && n < 300) begin
            @(negedge clk);
            n++;
        end
        while (div_rst && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("settle_reached", int'(n < 300), 1);
        rst = 1'b1;
        req = '0;
        sbq.delete();
        @(posedge clk); #1;
        chk("midrst_div_in", int'(div_in), 15);
        chk("midrst_div_rst", int'(div_rst), 1);
        chk("midrst_ack", int'(ack), 0);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_locked", int'(locked), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        rst_run = 0;
        pulses  = 0;
        issue(0, 4'd6, 0, 4'd6, 0);
        drain();
        chk("post_rst_div_in", int'(div_in), 6);

        repeat (5) @(negedge clk);
        chk("final_queue", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
